mult_unit: RTL
==============

// Module: mult_unit
// PURPOSE
//  Iterative radix-2 shift-add multiplier executing MULT/MULTU for the pipelined core.
//  - Sits beside the EX stage and writes the HI/LO register pair.
//  - Its mult_active output feeds the hazard unit, which stalls F/D while a product is pending.
//  - Operands are captured from the D-stage register-file/forwarding outputs on start_multD.
// PARAMETERS
//  WIDTH   32   operand width; product is 2*WIDTH, split into HI (upper) and LO (lower)
// PORTS
//  clk          in   1      system clock, rising edge
//  reset        in   1      asynchronous, active-high reset
//  start_multD  in   1      MULT/MULTU decoded in D; request to start a multiply
//  signed_opD   in   1      1 = MULT (signed), 0 = MULTU; used only with MULT_SIGNED_EN
//  srcAD        in   WIDTH  multiplicand (rs value, post-forwarding)
//  srcBD        in   WIDTH  multiplier (rt value, post-forwarding)
//  mult_active  out  1      high while a multiply is in progress (to hazard unit)
//  mult_done    out  1      one-cycle pulse in the cycle HI/LO take the new result
//  hi           out  WIDTH  HI register (MFHI source)
//  lo           out  WIDTH  LO register (MFLO source)
// BEHAVIOUR
//  - Reset: IDLE, mult_active=0, mult_done=0, hi=0, lo=0, counter=0, accumulator=0.
//  - FSM states: IDLE, BUSY, DONE.
//  - IDLE -> BUSY on a clk edge with start_multD=1:
//    - latch the multiplicand zero-extended to 2*WIDTH and the multiplier;
//    - clear the accumulator; set counter=WIDTH-1; mult_active=1 from the next cycle.
//  - BUSY, each cycle:
//    - if multiplier[0]=1: acc <= acc + mcand; mcand <<= 1; multiplier >>= 1;
//    - counter decrements; at counter==0, go to DONE.
//  - DONE, one cycle:
//    - {hi,lo} <= final product (sign-fixed if enabled); mult_done=1; mult_active=0;
//    - next state is IDLE.
//  - Latency: exactly WIDTH+1 cycles from the start edge to the hi/lo update.
//    - mult_active is high for WIDTH cycles (all of BUSY).
//  - Sum width: 2*WIDTH bits; carry-out beyond 2*WIDTH is discarded (it cannot occur for unsigned).
//  - hi/lo hold their previous value throughout BUSY; they are written only in DONE.
//  - start_multD while BUSY or DONE: ignored, with no restart and no operand recapture.
//    - The hazard unit guarantees this case does not occur; the block tolerates it.
//  - start_multD in the same cycle as DONE: ignored; a new start is accepted only from IDLE.
//  - Operand 0 or 1 is not special-cased; latency is fixed and has no early exit.
//  - Reset asserted mid-operation: immediate abort to the reset state.
//    - hi/lo are cleared and no mult_done pulse is produced.
// CONFIGURATION
//  MULT_SIGNED_EN defined:
//    - if signed_opD=1, latch |srcAD| and |srcBD| and record sign = srcAD[MSB]^srcBD[MSB];
//    - in DONE, write the two's-complement negation of the product when sign=1;
//    - the most-negative operand magnitude is 2^(WIDTH-1), represented correctly as unsigned;
//    - latency is unchanged.
//  MULT_SIGNED_EN undefined: all multiplies are unsigned; signed_opD is ignored (left unconnected).
// TESTING
//  - Reset: assert reset mid-BUSY -> mult_active=0, hi=0, lo=0 asynchronously; no mult_done.
//  - Unsigned: srcA=0x0000_0003, srcB=0x0000_0005 -> after 33 cycles hi=0, lo=0x0000_000F;
//    mult_active high for exactly 32 cycles; mult_done one pulse.
//  - Max unsigned: 0xFFFF_FFFF * 0xFFFF_FFFF -> hi=0xFFFF_FFFE, lo=0x0000_0001.
//  - Signed (MULT_SIGNED_EN): 0xFFFF_FFFE(-2) * 0x0000_0003 signed -> hi=0xFFFF_FFFF, lo=0xFFFF_FFFA;
//    same operands with signed_opD=0 -> hi=0x0000_0002, lo=0xFFFF_FFFA.
//  - Busy start: pulse start_multD with new operands at cycle 10 of BUSY -> ignored;
//    the original product completes on schedule and hi/lo hold their old value until DONE.
//  - Back-to-back: start asserted in the DONE cycle, then again in the following IDLE cycle ->
//    only the second start is accepted; mult_active returns high one cycle after it.

Source files
------------

// File: rtl/mult_unit.sv
// mult_unit -- iterative radix-2 shift-add multiplier for MULT/MULTU, writes HI/LO.
// Latency: WIDTH+1 cycles from the accepting clk edge to the HI/LO update; fixed, no early exit.
// Backpressure: none; a start is accepted only in IDLE, and a start seen while BUSY/DONE is dropped.
//
// Ports:
//   clk          rising-edge system clock
//   reset        asynchronous, active-high; aborts any multiply, clears HI/LO
//   start_multD  MULT/MULTU decoded in D; operands are captured on this edge when idle
//   signed_opD   1 = MULT (signed), 0 = MULTU; only honoured when MULT_SIGNED_EN is defined
//   srcAD/srcBD  multiplicand / multiplier from the D-stage forwarding muxes
//   mult_active  high for all WIDTH cycles of the iteration (hazard unit stalls F/D on it)
//   mult_done    one-cycle pulse; HI/LO take the new product on the clk edge that ends it
//   hi/lo        upper / lower halves of the 2*WIDTH-bit product
//
// Build option: define MULT_SIGNED_EN to support signed MULT (magnitude multiply plus
// a final two's-complement negation). Without it every multiply is unsigned.

module mult_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_multD,
  input  logic             signed_opD,
  input  logic [WIDTH-1:0] srcAD,
  input  logic [WIDTH-1:0] srcBD,
  output logic             mult_active,
  output logic             mult_done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         r_state;
  logic [2*WIDTH-1:0] r_mcand;   // multiplicand, shifted left once per step
  logic [WIDTH-1:0]   r_mplier;  // multiplier, shifted right once per step
  logic [2*WIDTH-1:0] r_acc;     // partial product
  logic [CW-1:0]      r_count;   // steps remaining after the current one
  logic               r_sign;    // negate the magnitude product in DONE
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic [WIDTH-1:0]   w_op_a;
  logic [WIDTH-1:0]   w_op_b;
  logic               w_sign;
  logic [2*WIDTH-1:0] w_sum;
  logic [2*WIDTH-1:0] w_product;

  // ---------------------------------------------------------------------------
  // Operand conditioning at capture time.
  // ---------------------------------------------------------------------------
`ifdef MULT_SIGNED_EN
  logic w_neg_a;
  logic w_neg_b;

  assign w_neg_a = signed_opD & srcAD[WIDTH-1];
  assign w_neg_b = signed_opD & srcBD[WIDTH-1];

  // Unary minus of the most-negative value yields 2^(WIDTH-1), which is exactly
  // the right magnitude once the datapath treats it as unsigned.
  assign w_op_a = w_neg_a ? -srcAD : srcAD;
  assign w_op_b = w_neg_b ? -srcBD : srcBD;
  assign w_sign = w_neg_a ^ w_neg_b;

  assign w_product = r_sign ? -r_acc : r_acc;
`else
  logic w_unused_signed_op;

  assign w_unused_signed_op = signed_opD;
  assign w_op_a    = srcAD;
  assign w_op_b    = srcBD;
  assign w_sign    = 1'b0;
  assign w_product = r_acc;
`endif

  // Accumulate at full product width; a carry past bit 2*WIDTH-1 cannot arise
  // for a magnitude product, so it is simply dropped.
  assign w_sum = r_acc + r_mcand;

  // ---------------------------------------------------------------------------
  // Control FSM and datapath.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_count  <= '0;
      r_sign   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_multD) begin
            r_mcand  <= {{WIDTH{1'b0}}, w_op_a};
            r_mplier <= w_op_b;
            r_acc    <= '0;
            r_count  <= CW'(WIDTH - 1);
            r_sign   <= w_sign;
            r_state  <= S_BUSY;
          end
        end

        S_BUSY: begin
          if (r_mplier[0]) begin
            r_acc <= w_sum;
          end
          r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
          // The step taken with r_count==0 is the last of WIDTH steps.
          if (r_count == '0) begin
            r_state <= S_DONE;
          end else begin
            r_count <= r_count - CW'(1);
          end
        end

        S_DONE: begin
          // A start arriving here is deliberately dropped: only IDLE accepts.
          {r_hi, r_lo} <= w_product;
          r_state      <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // State decodes are glitch-free register outputs and fall to zero the moment
  // reset asserts, so an abort never emits a done pulse.
  assign mult_active = (r_state == S_BUSY);
  assign mult_done   = (r_state == S_DONE);
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule
